vga_timing_generator: RTL

// - Parametrised VGA raster timing generator: horizontal and vertical counters, HSYNC/VSYNC, data-enable and scaled pixel coordinates.
// - Scaled coordinates address a low-resolution frame buffer in which each stored pixel covers SCALE x SCALE screen pixels.
// - Sits between the pixel clock domain and the frame-buffer read / colour output stage.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 98 +++++++++
 rtl/vga_timing_generator.sv | 97 +++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Package: vga_timing_pkg
// Shared definitions for the VGA raster timing generator.
//   - Default 640x480@60 timing values (pixels / lines).
//   - clog2_total(): bit width needed to hold the values 0..n-1 (minimum 1).
//   - vga_region_e: the four regions of one axis, in raster order.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_SCALE    = 5;

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    ACTIVE      = 2'd2,
    FRONT_PORCH = 2'd3
  } vga_region_e;

  // Width of a counter covering 0..n-1; a single value still needs one bit.
  function automatic int clog2_total(input int n);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Module: vga_axis_counter
// One raster axis (horizontal or vertical): wrapping position counter,
// region decode, SCALE phase counter and scaled-coordinate counter.
// All decoded outputs are registered from the next count value, so they
// line up with cnt in the same cycle.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   step         advance the axis by one position this clock
//   cnt          current position, 0..TOTAL-1
//   scl          scaled coordinate inside the active range, else 0
//   in_sync      cnt is inside the sync region
//   in_active    cnt is inside the active region
//   wrap_out     step while cnt is at TOTAL-1 (the axis wraps on this edge)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC_LEN   = 96,
  parameter int BP_LEN     = 48,
  parameter int ACTIVE_LEN = 640,
  parameter int FP_LEN     = 16,
  parameter int SCALE      = 5,
  parameter int CW         = 10,
  parameter int SW         = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic [SW-1:0] scl,
  output logic          in_sync,
  output logic          in_active,
  output logic          wrap_out
);

  localparam int TOTAL = SYNC_LEN + BP_LEN + ACTIVE_LEN + FP_LEN;
  localparam int PW    = clog2_total(SCALE);

  localparam logic [CW-1:0] CNT_LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_END    = CW'(SYNC_LEN);
  localparam logic [CW-1:0] ACT_START   = CW'(SYNC_LEN + BP_LEN);
  localparam logic [CW-1:0] ACT_END     = CW'(SYNC_LEN + BP_LEN + ACTIVE_LEN);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(SCALE - 1);

  logic [CW-1:0] cnt_next;
  logic [PW-1:0] phase;
  logic          last;
  vga_region_e   region_next;

  function automatic vga_region_e region_of(input logic [CW-1:0] c);
    if (c < SYNC_END)       return SYNC;
    else if (c < ACT_START) return BACK_PORCH;
    else if (c < ACT_END)   return ACTIVE;
    else                    return FRONT_PORCH;
  endfunction

  // Next position and the region it falls in.
  always_comb begin
    cnt_next = '0;
    if (last) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
    region_next = region_of(cnt_next);
  end

  // Terminal flag is registered so the wrap decision needs no comparator.
  assign wrap_out = step & last;

  // Position, decoded flags and scaled coordinate, all updated on a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      last      <= 1'b0;
      in_sync   <= 1'b1;
      in_active <= 1'b0;
      phase     <= '0;
      scl       <= '0;
    end else if (step) begin
      cnt       <= cnt_next;
      last      <= (cnt_next == CNT_LAST);
      in_sync   <= (region_next == SYNC);
      in_active <= (region_next == ACTIVE);
      // The phase restarts on the first active position, so each scaled
      // coordinate spans exactly SCALE positions from there on.
      if ((region_next != ACTIVE) || (cnt_next == ACT_START)) begin
        phase <= '0;
        scl   <= '0;
      end else if (phase == PHASE_LAST) begin
        phase <= '0;
        scl   <= scl + 1'b1;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Module: vga_timing_generator
// Parametrised VGA raster timing generator. Produces the raster position,
// sync pulses, data enable, line/frame pulses and scaled coordinates that
// address a low-resolution frame buffer (each stored pixel covers
// SCALE x SCALE screen pixels).
// Build option: define VGA_TIMING_PIXEL_CE_EN to add the pix_ce port; the
// raster then advances only on clocks with pix_ce=1. Without it the raster
// advances every clock.
// Ports:
//   clk, reset          pixel clock, asynchronous active-high reset
//   pix_ce              pixel clock enable (VGA_TIMING_PIXEL_CE_EN only)
//   h_cnt, v_cnt        raster position
//   scl_x, scl_y        scaled column / row, 0 outside the active area
//   hsync, vsync        sync outputs, active level H_SYNC_POL / V_SYNC_POL
//   de                  active video
//   new_line            pulse on the advancing clock of the last pixel of a line
//   new_frame           pulse on the advancing clock of the last pixel of a frame
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter int   SCALE      = DEF_SCALE,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
`ifdef VGA_TIMING_PIXEL_CE_EN
  input  logic pix_ce,
`endif
  output logic [clog2_total(H_SYNC+H_BP+H_ACTIVE+H_FP)-1:0] h_cnt,
  output logic [clog2_total(V_SYNC+V_BP+V_ACTIVE+V_FP)-1:0] v_cnt,
  output logic [clog2_total(H_ACTIVE/SCALE)-1:0]            scl_x,
  output logic [clog2_total(V_ACTIVE/SCALE)-1:0]            scl_y,
  output logic hsync,
  output logic vsync,
  output logic de,
  output logic new_line,
  output logic new_frame
);

  localparam int HW  = clog2_total(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam int VW  = clog2_total(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam int SXW = clog2_total(H_ACTIVE / SCALE);
  localparam int SYW = clog2_total(V_ACTIVE / SCALE);

  if ((SCALE < 1) || (SCALE > 8) || (H_ACTIVE % SCALE != 0) ||
      (V_ACTIVE % SCALE != 0) || (H_SYNC == 0) || (H_BP == 0) ||
      (H_FP == 0) || (V_SYNC == 0) || (V_BP == 0) || (V_FP == 0)) begin : g_bad_cfg
    $error("vga_timing_generator: illegal timing or SCALE parameters");
  end

  logic advance;
  logic h_wrap;
  logic h_in_sync;
  logic h_in_active;
  logic v_in_sync;
  logic v_in_active;

`ifdef VGA_TIMING_PIXEL_CE_EN
  assign advance = pix_ce;
`else
  assign advance = 1'b1;
`endif

  vga_axis_counter #(
    .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP),
    .SCALE(SCALE), .CW(HW), .SW(SXW)
  ) u_h_axis (
    .clk(clk), .reset(reset), .step(advance),
    .cnt(h_cnt), .scl(scl_x), .in_sync(h_in_sync), .in_active(h_in_active),
    .wrap_out(h_wrap)
  );

  // The vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP),
    .SCALE(SCALE), .CW(VW), .SW(SYW)
  ) u_v_axis (
    .clk(clk), .reset(reset), .step(h_wrap),
    .cnt(v_cnt), .scl(scl_y), .in_sync(v_in_sync), .in_active(v_in_active),
    .wrap_out(new_frame)
  );

  assign new_line = h_wrap;
  assign hsync    = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
  assign vsync    = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
  assign de       = h_in_active & v_in_active;

endmodule
